fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch front end that sits directly upstream of the fetch/decode pipeline buffer. It owns the program counter and issues one instruction-memory request at a time over a req/ack handshake, so the memory may have variable latency. Returned instructions are buffered with their PC+4 in a small FIFO. It presents them to the fetch/decode buffer under a stall signal, and flushes on a branch redirect from the memory stage.

## Interface
- DEPTH, 4: number of FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- memReq_o  out  1  instruction-memory request valid.
- memAddr_o  out  32  request address; word aligned.
- memAck_i  in  1  memory completes the request this cycle; sampled only while memReq_o=1.
- memData_i  in  32  instruction word; valid in the cycle memAck_i=1.
- redirect_i  in  1  branch taken (pcSrc from the memory stage).
- redirectPc_i  in  32  branch target address.
- stall_i  in  1  downstream not accepting this cycle.
- instrValid_o  out  1  FIFO head is valid.
- instr_o  out  32  instruction word at the FIFO head.
- nextInstrAddr_o  out  32  address of the head instruction + 4.

## Operation
- **Registers:**
  - fetchPc: next address to request.
  - reqPc: address of the in-flight request.
  - FIFO storage, read pointer, write pointer, and count (0..DEPTH).
  - 2-bit state.
- **Outputs:**
  - memAddr_o = reqPc.
  - memReq_o = 1 in REQ and DROP.
  - instrValid_o = (count != 0).
  - instr_o and nextInstrAddr_o are the head entry's fields.
- **Handshake rules:**
  - A transfer occurs when memReq_o && memAck_i.
  - memAddr_o is held constant from request assertion until the transfer.
  - At most one request is outstanding.
- **States:**
  - IDLE (no request).
    - If redirect_i: flush, fetchPc ← redirectPc_i, then go to REQ.
    - Else if count < DEPTH: go to REQ.
    - On entry to REQ: reqPc ← fetchPc and fetchPc ← fetchPc+4.
  - REQ (request whose result is kept).
    - Ack without redirect: push {memData_i, reqPc+4}.
      - If count_next < DEPTH: stay in REQ with reqPc ← fetchPc, fetchPc ← fetchPc+4 (back-to-back).
      - Otherwise go to IDLE.
    - Redirect with ack: data discarded, flush, reqPc ← redirectPc_i, fetchPc ← redirectPc_i+4, stay in REQ.
    - Redirect without ack: flush, fetchPc ← redirectPc_i, go to DROP (reqPc held).
  - DROP (in-flight request whose result is discarded).
    - Ack: data discarded, reqPc ← fetchPc, fetchPc ← fetchPc+4, go to REQ.
    - Redirect with no ack: fetchPc ← redirectPc_i, stay in DROP.
    - Redirect with ack: reqPc ← redirectPc_i, fetchPc ← redirectPc_i+4, go to REQ.
- **Pop:** occurs when instrValid_o && !stall_i && !redirect_i.
- **Simultaneous events:**
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop when count=0 is impossible, because instrValid_o=0.
  - A push into a full FIFO cannot occur, because REQ is entered only when count < DEPTH.
- **Redirect priority:** redirect_i has priority over push and pop. The flush sets count=0 and equalises the pointers.
- **Arithmetic:** PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. Pointers wrap modulo DEPTH.
- **Reset values:**
  - state = IDLE, fetchPc = RESET_PC, reqPc = 0.
  - count and pointers = 0; storage cleared to 0.
  - Resulting outputs: memReq_o=0, memAddr_o=0, instrValid_o=0, instr_o=0, nextInstrAddr_o=0.
- **Reset during a request:** rst_i mid-request abandons it. An ack arriving in the reset or IDLE state is ignored.

## Timing
- First request appears 1 cycle after reset release: memReq_o=1, memAddr_o=RESET_PC.
- Ack in cycle n makes the instruction visible at the head in cycle n+1 (registered FIFO), if no older entries are queued.
- Throughput with zero-wait memory (ack the same cycle as req): 1 instruction per cycle.
- Redirect in cycle n:
  - instrValid_o=0 in cycle n+1.
  - First request to the target is at n+1 if no ack is pending, otherwise 1 cycle after the discarded ack.
- Refill from full: one pop in cycle n gives count<DEPTH in n+1, REQ in n+2 (IDLE→REQ costs 1 cycle).
- Ready for downstream: stall_i may toggle freely, and the head holds stable while stalled.

## Test plan
- **Reset and free-run:** rst_i pulse with memAck_i tied 1 and stall_i=0 → addresses 0,4,8,... on consecutive cycles. Head (instr, nextInstrAddr) = (mem[0],4), (mem[4],8), ... one per cycle, starting 2 cycles after reset release.
- **Fill under stall:** stall_i=1 with DEPTH=4 and immediate acks → exactly 4 transfers (addresses 0..12), then memReq_o=0 and the head stays mem[0]. Releasing stall for 1 cycle → a single request to 16 follows.
- **Variable latency:** ack delayed 3 cycles → memAddr_o held constant across the wait and the data enqueued once. Inserting ack=1 while memReq_o=0 → no push.
- **Redirect with outstanding request:** issue to 0x20, assert redirect_i to 0x100 at ack delay 2 → DROP keeps memAddr_o=0x20 until ack, 0x20's data is discarded, the next request is 0x100, and the head gives (mem[0x100],0x104).
- **Redirect with same-cycle ack and pop:** FIFO holds 2 entries; assert redirect_i=1, memAck_i=1 and stall_i=0 together → count=0 next cycle, no pop or push recorded, and the next memAddr_o=target.
- **Wrap and async reset:** redirect to 0xFFFF_FFFC → the next address is 0x0 and nextInstrAddr_o=0x0. Asynchronous rst_i mid-wait → outputs are at reset values before the next edge.

Source files
------------

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end. Owns the program counter, issues one
// instruction-memory request at a time over a req/ack handshake (variable
// memory latency), buffers returned words with their PC+4 in a small FIFO
// and presents the FIFO head to the fetch/decode buffer under stall_i.
// A branch redirect flushes the FIFO and restarts fetching at the target.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   memReq_o         instruction-memory request valid
//   memAddr_o        request address (held until the transfer)
//   memAck_i         memory completes the request this cycle
//   memData_i        instruction word, valid with memAck_i
//   redirect_i       branch taken, flush and refetch
//   redirectPc_i     branch target address
//   stall_i          downstream not accepting this cycle
//   instrValid_o     FIFO head valid
//   instr_o          instruction word at the FIFO head
//   nextInstrAddr_o  head instruction address + 4
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        memReq_o,
    output logic [31:0] memAddr_o,
    input  logic        memAck_i,
    input  logic [31:0] memData_i,
    input  logic        redirect_i,
    input  logic [31:0] redirectPc_i,
    input  logic        stall_i,
    output logic        instrValid_o,
    output logic [31:0] instr_o,
    output logic [31:0] nextInstrAddr_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no request outstanding
        REQ  = 2'd1,   // request whose result is kept
        DROP = 2'd2    // request whose result is discarded after a redirect
    } state_t;

    state_t         state_reg, state_next;
    logic [31:0]    fetch_pc_reg, fetch_pc_next;
    logic [31:0]    req_pc_reg, req_pc_next;
    logic [PW-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0]  count_reg, count_next;
    logic [31:0]    instr_mem [DEPTH];
    logic [31:0]    addr_mem  [DEPTH];

    logic           push;
    logic           pop;
    logic [CW-1:0]  count_with_push;

    assign memReq_o        = (state_reg != IDLE);
    assign memAddr_o       = req_pc_reg;
    assign instrValid_o    = (count_reg != '0);
    assign instr_o         = instr_mem[rd_ptr_reg];
    assign nextInstrAddr_o = addr_mem[rd_ptr_reg];

    // Redirect wins over a pop in the same cycle.
    assign pop = instrValid_o && !stall_i && !redirect_i;

    // Occupancy if the current ack is pushed; REQ only runs with count < DEPTH,
    // so this never exceeds DEPTH.
    assign count_with_push = count_reg + CW'(1) - CW'(pop);

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_pc_next   = req_pc_reg;
        push          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (redirect_i) begin
                    // Load the target and enter REQ in one step.
                    state_next    = REQ;
                    req_pc_next   = redirectPc_i;
                    fetch_pc_next = redirectPc_i + 32'd4;
                end else if (count_reg < FULL) begin
                    state_next    = REQ;
                    req_pc_next   = fetch_pc_reg;
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    if (memAck_i) begin
                        // Old request finished now; target can go out next cycle.
                        req_pc_next   = redirectPc_i;
                        fetch_pc_next = redirectPc_i + 32'd4;
                    end else begin
                        // Request still in flight: keep its address, drop its data.
                        fetch_pc_next = redirectPc_i;
                        state_next    = DROP;
                    end
                end else if (memAck_i) begin
                    push = 1'b1;
                    if (count_with_push < FULL) begin
                        req_pc_next   = fetch_pc_reg;
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (memAck_i) begin
                    state_next = REQ;
                    if (redirect_i) begin
                        req_pc_next   = redirectPc_i;
                        fetch_pc_next = redirectPc_i + 32'd4;
                    end else begin
                        req_pc_next   = fetch_pc_reg;
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                    end
                end else if (redirect_i) begin
                    fetch_pc_next = redirectPc_i;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (redirect_i) begin
            count_next = '0;
        end else begin
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            req_pc_reg   <= 32'd0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            req_pc_reg   <= req_pc_next;
            count_reg    <= count_next;
            if (redirect_i) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
            end
        end
    end

    // Storage is cleared on reset so the head outputs read zero when empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem[i] <= 32'd0;
                addr_mem[i]  <= 32'd0;
            end
        end else if (push) begin
            instr_mem[wr_ptr_reg] <= memData_i;
            addr_mem[wr_ptr_reg]  <= req_pc_reg + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed self-checking bench for fetch_queue (DEPTH=4, RESET_PC=0).
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, so every check sees the state registered at that edge.
// The memory model returns addr ^ 32'hC0DE_0000 for every address.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] next_instr_addr;

    int n_checks;
    int n_fail;

    fetch_queue #(
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .memReq_o       (mem_req),
        .memAddr_o      (mem_addr),
        .memAck_i       (mem_ack),
        .memData_i      (mem_data),
        .redirect_i     (redirect),
        .redirectPc_i   (redirect_pc),
        .stall_i        (stall),
        .instrValid_o   (instr_valid),
        .instr_o        (instr),
        .nextInstrAddr_o(next_instr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign mem_data = mem_word(mem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with the given inputs, then release it.
    // The next tick() after this returns is the first edge out of reset.
    task automatic do_reset(input logic ack, input logic stl);
        rst         = 1'b1;
        mem_ack     = ack;
        stall       = stl;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ack = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        tick();
        tick();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", mem_req); end
        n_checks++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000000", mem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        n_checks++; if (instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
        n_checks++; if (next_instr_addr !== 32'd0) begin n_fail++; $display("FAIL reset_nia: got %h expected 00000000", next_instr_addr); end
        rst = 1'b0;
        tick();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd0) begin n_fail++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000", mem_req, mem_addr); end
        $display("test_reset done");
    endtask

    task automatic test_free_run();
        do_reset(1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL free_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h", k, mem_req, mem_addr, 32'(4 * k)); end
            if (k == 0) begin
                n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL free_valid0: got %b expected 0", instr_valid); end
            end else begin
                n_checks++; if (instr_valid !== 1'b1 || instr !== mem_word(32'(4 * (k - 1))) || next_instr_addr !== 32'(4 * k)) begin
                    n_fail++; $display("FAIL free_head[%0d]: got v=%b instr=%h nia=%h expected v=1 instr=%h nia=%h", k, instr_valid, instr, next_instr_addr, mem_word(32'(4 * (k - 1))), 32'(4 * k));
                end
            end
            $display("free_run cycle %0d addr=%h head=%h", k, mem_addr, instr);
        end
    endtask

    task automatic test_fill_stall();
        int transfers;
        transfers = 0;
        do_reset(1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (mem_req && mem_ack) transfers++;
        end
        n_checks++; if (transfers !== 4) begin n_fail++; $display("FAIL fill_transfers: got %0d expected 4", transfers); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fill_idle: got req=%b expected 0", mem_req); end
        n_checks++; if (instr !== mem_word(32'd0) || next_instr_addr !== 32'd4) begin n_fail++; $display("FAIL fill_head: got %h/%h expected %h/00000004", instr, next_instr_addr, mem_word(32'd0)); end
        // One cycle without stall: one pop, then exactly one refill request.
        stall = 1'b0;
        tick();
        stall = 1'b1;
        n_checks++; if (mem_req !== 1'b0 || instr !== mem_word(32'd4) || next_instr_addr !== 32'd8) begin n_fail++; $display("FAIL fill_pop: got req=%b head=%h/%h expected req=0 head=%h/00000008", mem_req, instr, next_instr_addr, mem_word(32'd4)); end
        tick();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd16) begin n_fail++; $display("FAIL fill_refill: got req=%b addr=%h expected req=1 addr=00000010", mem_req, mem_addr); end
        tick();
        n_checks++; if (mem_req !== 1'b0 || instr !== mem_word(32'd4)) begin n_fail++; $display("FAIL fill_refull: got req=%b head=%h expected req=0 head=%h", mem_req, instr, mem_word(32'd4)); end
        $display("fill_stall transfers=%0d", transfers);
    endtask

    task automatic test_variable_latency();
        // Ack while still IDLE (first cycle after reset) must not push.
        do_reset(1'b1, 1'b0);
        tick();
        mem_ack = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'd0) begin n_fail++; $display("FAIL idle_ack: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000000", instr_valid, mem_req, mem_addr); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_hold[%0d]: got req=%b addr=%h v=%b expected req=1 addr=00000000 v=0", k, mem_req, mem_addr, instr_valid); end
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr !== mem_word(32'd0) || next_instr_addr !== 32'd4 || mem_addr !== 32'd4) begin n_fail++; $display("FAIL late_push: got v=%b instr=%h nia=%h addr=%h expected v=1 instr=%h nia=00000004 addr=00000004", instr_valid, instr, next_instr_addr, mem_addr, mem_word(32'd0)); end
        tick();
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL single_push: got v=%b expected 0", instr_valid); end
        $display("variable_latency done addr=%h", mem_addr);
    endtask

    task automatic test_redirect_outstanding();
        do_reset(1'b0, 1'b0);
        redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin n_fail++; $display("FAIL redir_idle: got req=%b addr=%h expected req=1 addr=00000020", mem_req, mem_addr); end
        tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        n_checks++; if (mem_addr !== 32'h20 || mem_req !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL drop_hold: got addr=%h req=%b v=%b expected addr=00000020 req=1 v=0", mem_addr, mem_req, instr_valid); end
        tick();
        n_checks++; if (mem_addr !== 32'h20) begin n_fail++; $display("FAIL drop_hold2: got addr=%h expected 00000020", mem_addr); end
        mem_ack = 1'b1;
        tick();
        n_checks++; if (mem_addr !== 32'h100 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL drop_discard: got addr=%h v=%b expected addr=00000100 v=0", mem_addr, instr_valid); end
        tick();
        n_checks++; if (instr_valid !== 1'b1 || instr !== mem_word(32'h100) || next_instr_addr !== 32'h104) begin n_fail++; $display("FAIL redir_head: got v=%b instr=%h nia=%h expected v=1 instr=%h nia=00000104", instr_valid, instr, next_instr_addr, mem_word(32'h100)); end
        $display("redirect_outstanding head=%h nia=%h", instr, next_instr_addr);
    endtask

    // Continues from test_redirect_outstanding: one entry queued, ack held high.
    task automatic test_redirect_same_cycle();
        stall = 1'b1;
        tick();
        n_checks++; if (instr !== mem_word(32'h100) || mem_addr !== 32'h108) begin n_fail++; $display("FAIL two_entries: got head=%h addr=%h expected head=%h addr=00000108", instr, mem_addr, mem_word(32'h100)); end
        redirect = 1'b1; redirect_pc = 32'h200; mem_ack = 1'b1; stall = 1'b0;
        tick();
        redirect = 1'b0; mem_ack = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL flush_ack: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000200", instr_valid, mem_req, mem_addr); end
        tick();
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got v=%b expected 0", instr_valid); end
        mem_ack = 1'b1;
        tick();
        n_checks++; if (instr_valid !== 1'b1 || instr !== mem_word(32'h200) || next_instr_addr !== 32'h204) begin n_fail++; $display("FAIL flush_refetch: got v=%b instr=%h nia=%h expected v=1 instr=%h nia=00000204", instr_valid, instr, next_instr_addr, mem_word(32'h200)); end
        $display("redirect_same_cycle head=%h", instr);
    endtask

    task automatic test_wrap_and_async_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; mem_ack = 1'b1; stall = 1'b1;
        tick();
        redirect = 1'b0;
        n_checks++; if (mem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_req: got addr=%h v=%b expected addr=fffffffc v=0", mem_addr, instr_valid); end
        tick();
        mem_ack = 1'b0;
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 00000000", mem_addr); end
        n_checks++; if (instr !== mem_word(32'hFFFF_FFFC) || next_instr_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_nia: got instr=%h nia=%h expected instr=%h nia=00000000", instr, next_instr_addr, mem_word(32'hFFFF_FFFC)); end
        tick();
        // Mid-cycle asynchronous reset while waiting on the request to 0x0.
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0 || mem_addr !== 32'd0 || instr_valid !== 1'b0 || instr !== 32'd0 || next_instr_addr !== 32'd0) begin
            n_fail++; $display("FAIL async_reset: got req=%b addr=%h v=%b instr=%h nia=%h expected all zero", mem_req, mem_addr, instr_valid, instr, next_instr_addr);
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL restart: got req=%b addr=%h v=%b expected req=1 addr=00000000 v=0", mem_req, mem_addr, instr_valid); end
        $display("wrap_and_async_reset done");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_free_run();
        test_fill_stall();
        test_variable_latency();
        test_redirect_outstanding();
        test_redirect_same_cycle();
        test_wrap_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
